// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the request-merge pipeline.
// Holds the index-width helper and the lock-FSM state encoding.
package pipeline_pkg;

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

endpackage

// File: rtl/pipeline_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first request at or above i_ptr, wrapping N-1 to 0.
module rr_pick
   import pipeline_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [IW-1:0] o_grant
);

   // Walk the ring from the far end so the nearest request wins.
   always_comb begin
      o_any   = 1'b0;
      o_grant = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) begin
            o_any   = 1'b1;
            o_grant = IW'((int'(i_ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin merge of N valid/ready streams into one output register.
// Multi-beat transactions hold the grant until their last beat.
module pipeline_rr_arbiter
   import pipeline_pkg::*;
#(
   parameter int N  = 2,
   parameter int DW = 256,
   localparam int IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  i_valid,
   output logic [N-1:0]  i_ready,
   input  logic [DW-1:0] i_data [N],
   input  logic [N-1:0]  i_last,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_data,
   output logic          o_last,
   output logic [IW-1:0] o_id
);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic          r_full;
   logic [DW-1:0] r_data;
   logic          r_last;
   logic [IW-1:0] r_id;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_lock_id;
   logic [IW-1:0] w_ptr_nxt;
   logic [IW-1:0] w_lock_nxt;
   logic          w_pick_any;
   logic [IW-1:0] w_pick_g;
   logic [IW-1:0] w_grant;
   logic          w_gvalid;
   logic          w_glast;
   logic          w_can_accept;
   logic          w_accept;

   rr_pick #(.N(N)) u_pick (
      .i_req   (i_valid),
      .i_ptr   (r_ptr),
      .o_any   (w_pick_any),
      .o_grant (w_pick_g)
   );

   // While locked the grant is pinned, even if that lane is idle.
   always_comb begin
      w_grant      = w_pick_g;
      w_gvalid     = w_pick_any;
      if (r_state == ARB_LOCKED) begin
         w_grant   = r_lock_id;
         w_gvalid  = i_valid[r_lock_id];
      end
      w_can_accept = !r_full || o_ready;
      w_accept     = rst_n && w_can_accept && w_gvalid;
      w_glast      = i_last[w_grant];
      i_ready      = '0;
      if (w_accept) begin
         i_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock_id;
      w_ptr_nxt   = r_ptr;
      if (w_accept) begin
         unique case (r_state)
            ARB_IDLE: begin
               if (!w_glast) begin
                  w_state_nxt = ARB_LOCKED;
                  w_lock_nxt  = w_grant;
               end
            end
            ARB_LOCKED: begin
               if (w_glast) begin
                  w_state_nxt = ARB_IDLE;
               end
            end
            default: w_state_nxt = ARB_IDLE;
         endcase
         if (w_glast) begin
            w_ptr_nxt = IW'((int'(w_grant) + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ARB_IDLE;
         r_lock_id <= '0;
         r_ptr     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_nxt;
         r_ptr     <= w_ptr_nxt;
      end
   end

   // A new accept overwrites a beat being taken, so no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
         r_id   <= '0;
      end else if (w_accept) begin
         r_full <= 1'b1;
         r_data <= i_data[w_grant];
         r_last <= w_glast;
         r_id   <= w_grant;
      end else if (o_ready) begin
         r_full <= 1'b0;
      end
   end

   assign o_valid = r_full;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_id    = r_id;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Self-checking bench for pipeline_rr_arbiter (N=4).
// Directed scenarios plus randomized traffic against a queue model.
module tb_pipeline_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  i_valid;
   logic [N-1:0]  i_ready;
   logic [DW-1:0] i_data [N];
   logic [N-1:0]  i_last;
   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic [IW-1:0] o_id;

   always #5 clk = ~clk;

   pipeline_rr_arbiter #(.N(N), .DW(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .i_last  (i_last),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_id    (o_id)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            id;
   } beat_t;

   beat_t m_q[$];
   int    m_ptr;
   bit    m_lock;
   int    m_lock_id;
   int    e_g;
   bit    e_gv;

   int n_cycles    = 0;
   int n_checks    = 0;
   int miscompares = 0;

   int            t1_ids [5] = '{0, 1, 2, 3, 0};
   logic [DW-1:0] held;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ptr     = 0;
      m_lock    = 0;
      m_lock_id = 0;
   endtask

   task automatic model_grant();
      e_gv = 0;
      e_g  = 0;
      if (m_lock) begin
         e_g  = m_lock_id;
         e_gv = i_valid[e_g];
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!e_gv && i_valid[(m_ptr + k) % N]) begin
               e_gv = 1;
               e_g  = (m_ptr + k) % N;
            end
         end
      end
   endtask

   function automatic logic [N-1:0] exp_ready();
      bit can;
      can = (m_q.size() == 0) || o_ready;
      return (can && e_gv) ? (N'(1) << e_g) : '0;
   endfunction

   task automatic check_cycle();
      @(negedge clk);
      model_grant();
      n_cycles++;
      chk("i_ready", i_ready, exp_ready());
      chk("o_valid", o_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("o_data", o_data, m_q[0].d);
         chk("o_last", o_last, m_q[0].l);
         chk("o_id", o_id, m_q[0].id);
      end
   endtask

   task automatic advance();
      beat_t b;
      bit    acc;
      model_grant();
      acc = (exp_ready() != 0);
      if (m_q.size() != 0 && o_ready) begin
         void'(m_q.pop_front());
      end
      if (acc) begin
         b.d  = i_data[e_g];
         b.l  = i_last[e_g];
         b.id = e_g;
         m_q.push_back(b);
         if (!m_lock && !b.l) begin
            m_lock    = 1;
            m_lock_id = e_g;
         end else if (m_lock && b.l) begin
            m_lock = 0;
         end
         if (b.l) begin
            m_ptr = (e_g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_data();
      for (int i = 0; i < N; i++) begin
         i_data[i] = DW'($urandom());
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      i_valid = '0;
      i_last  = '0;
      o_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      o_ready = 1'b0;
      i_valid = '1;
      i_last  = '1;
      rnd_data();
      model_reset();
      #3;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_o_last", o_last, 0);
      chk("rst_o_id", o_id, 0);
      chk("rst_i_ready", i_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // rotation with single-beat transactions
      o_ready = 1'b1;
      check_cycle();
      chk("t1_first_ready", i_ready, 4'b0001);
      advance();
      for (int c = 0; c < 5; c++) begin
         rnd_data();
         check_cycle();
         chk("t1_id", o_id, t1_ids[c]);
         chk("t1_valid", o_valid, 1);
         advance();
      end

      // three-beat transaction from req0 blocks req1
      do_reset();
      o_ready = 1'b1;
      i_valid = 4'b0011;
      for (int b = 0; b < 3; b++) begin
         i_last = 4'b0010 | 4'(b == 2);
         rnd_data();
         check_cycle();
         chk("t2_ready", i_ready, 4'b0001);
         if (b > 0) chk("t2_id", o_id, 0);
         advance();
      end
      i_valid = 4'b0010;
      check_cycle();
      chk("t2_id3", o_id, 0);
      chk("t2_last3", o_last, 1);
      chk("t2_req1", i_ready, 4'b0010);
      advance();
      i_valid = '0;
      check_cycle();
      chk("t2_id4", o_id, 1);
      advance();

      // downstream stall holds the register
      do_reset();
      i_valid = '1;
      i_last  = '1;
      o_ready = 1'b1;
      rnd_data();
      held = i_data[0];
      check_cycle();
      advance();
      o_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         rnd_data();
         check_cycle();
         chk("t3_ready", i_ready, 0);
         chk("t3_data", o_data, held);
         chk("t3_id", o_id, 0);
         chk("t3_last", o_last, 1);
         advance();
      end
      o_ready = 1'b1;
      check_cycle();
      chk("t3_release", i_ready, 4'b0010);
      advance();
      check_cycle();
      chk("t3_next_id", o_id, 1);
      chk("t3_next_valid", o_valid, 1);
      advance();

      // pointer wrap
      do_reset();
      o_ready = 1'b1;
      i_last  = '1;
      i_valid = 4'b0100;
      check_cycle();
      chk("t4_req2", i_ready, 4'b0100);
      advance();
      i_valid = 4'b0010;
      check_cycle();
      chk("t4_req1", i_ready, 4'b0010);
      advance();
      i_valid = 4'b0101;
      check_cycle();
      chk("t4_req2_first", i_ready, 4'b0100);
      advance();
      i_valid = '0;
      check_cycle();
      advance();

      // locked requester goes idle
      do_reset();
      o_ready = 1'b1;
      i_valid = 4'b0100;
      i_last  = '0;
      check_cycle();
      chk("t5_lock", i_ready, 4'b0100);
      advance();
      i_valid = 4'b0001;
      i_last  = '1;
      for (int c = 0; c < 3; c++) begin
         check_cycle();
         chk("t5_stall", i_ready, 0);
         advance();
      end
      i_valid = 4'b0101;
      check_cycle();
      chk("t5_resume", i_ready, 4'b0100);
      advance();
      check_cycle();
      chk("t5_after", i_ready, 4'b0001);
      advance();
      i_valid = '0;
      check_cycle();
      advance();

      // asynchronous reset mid-transaction
      do_reset();
      o_ready = 1'b0;
      i_valid = '1;
      i_last  = '0;
      check_cycle();
      advance();
      check_cycle();
      chk("t6_full", o_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", o_valid, 0);
      chk("t6_async_ready", i_ready, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      i_last  = '1;
      o_ready = 1'b1;
      check_cycle();
      chk("t6_req0", i_ready, 4'b0001);
      advance();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         i_valid = N'($urandom());
         i_last  = N'($urandom());
         o_ready = ($urandom_range(0, 3) != 0);
         rnd_data();
         check_cycle();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_cycles, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_rr_arbiter.md
# pipeline_rr_arbiter

Round-robin arbiter that merges N valid/ready request streams onto one shared downstream resource, e.g. a single Montgomery multiplier serving several exponentiation lanes. It is the merge-side counterpart of the masked one-to-N distributor: each accepted beat is registered with its source index, so results can later be routed back through the distributor's mask. Multi-beat transactions, framed by a last flag, are never interleaved.

## Interface

- `N`, default 2, number of requesters; N ≥ 1.
- `DW`, default 256, payload width in bits.
- `IW`, default max(1, $clog2(N)), source-index width; derived, not overridden.

Ports:

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid[N]`  in  1  requester i has a beat.
- `i_ready[N]`  out  1  beat from requester i accepted this cycle.
- `i_data[N]`  in  DW  payload of requester i.
- `i_last[N]`  in  1  final beat of requester i's transaction.
- `o_valid`  out  1  output register holds a beat.
- `o_ready`  in  1  downstream accepts.
- `o_data`  out  DW  registered payload.
- `o_last`  out  1  registered last flag.
- `o_id`  out  IW  index of the requester that supplied the beat.

## Operation

- One-entry output register with a full flag; `o_valid` = full.
- `can_accept` = !full || o_ready.
- Grant, when unlocked: the first i with i_valid[i], scanning from `ptr` upward and wrapping N-1 → 0.
- Grant, when locked: always `lock_id`, whether or not it is valid.
- `i_ready[g]` = can_accept && i_valid[g] for the granted g. Every other `i_ready` is 0.
- An accept (i_valid[g] && i_ready[g]) loads data, last and g into the output register and sets full.
- A downstream take (o_valid && o_ready) with no accept in the same cycle clears full.
- Lock FSM, two states:
  - IDLE → LOCKED on an accept with i_last=0; lock_id ← g.
  - LOCKED → IDLE on an accept with i_last=1 from lock_id.
- `ptr` ← (g+1) mod N only on an accept with i_last=1. Single-beat transactions therefore rotate priority every beat.
- In LOCKED, other requesters stall even while the locked requester is idle. There is no timeout.
- N=1: ptr and lock are constant in effect; `o_id` is always 0.
- Payload passes through unmodified; no arithmetic on data.

## Timing

- Reset values:
  - o_valid=0, o_data=0, o_last=0, o_id=0.
  - full=0, ptr=0, state=IDLE, lock_id=0.
  - All i_ready=0 during reset.
- Latency is 1 cycle from an input accept to o_valid.
- Throughput is 1 beat/cycle while o_ready is held high.
- Simultaneous take and accept: the register is overwritten with the new beat and full stays 1, with no bubble.
- Combinational path o_ready → i_ready is permitted. There is no path from i_data to any output except through the register.
- o_data, o_last and o_id are stable while o_valid=1 && o_ready=0.
- At most one i_ready is high per cycle.
- Reset asserted mid-transaction drops any held beat and clears the lock immediately (asynchronously).

## Structure

- Shared package `pipeline_pkg`:
  - `function automatic int idx_w(int n)` returning max(1, $clog2(n)).
  - Lock-FSM `typedef enum logic {ARB_IDLE, ARB_LOCKED}`.
- Sub-module `rr_pick` (N):
  - Purely combinational.
  - Inputs: req[N] and ptr. Outputs: any and grant index.
  - The only place the wrap-around scan lives.
- Top level holds the output register, ptr, and the lock FSM.

## Test plan

- N=4, all i_valid=1 with i_last=1, o_ready=1 → o_id sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle, no bubbles.
- N=2: req0 sends a 3-beat transaction (last on beat 3) while req1 is valid throughout → o_id=0,0,0 then 1. i_ready[1]=0 until req0's last beat is accepted.
- o_ready=0 for 5 cycles with the register full → o_data, o_id and o_last stay constant, and all i_ready=0. On release, the held beat leaves and the next beat loads in the same cycle.
- ptr=3, N=4, only req1 valid → req1 granted and ptr becomes 2. Next, req0 and req2 both valid → req2 granted first.
- Locked on req2, req2 drops i_valid for 3 cycles while req0 is valid → no accepts. req2 resumes with i_last=1 → accepted, FSM returns to IDLE, and req0 is granted next.
- rst_n pulsed low mid-transaction while full → o_valid=0 immediately. After release, ptr=0 and the FSM is IDLE, so req0 wins if all requesters are valid.
